// File: rtl/tank_pkg.sv
// Shared types and default geometry for the tank motion controller.
package tank_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
  typedef enum logic [1:0] {IDLE, REQ, BREQ} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [9:0] X_START_DEF = 10'd320;
  localparam logic [9:0] Y_START_DEF = 10'd240;
  localparam logic [9:0] X_MIN_DEF   = 10'd0;
  localparam logic [9:0] X_MAX_DEF   = 10'd639;
  localparam logic [9:0] Y_MIN_DEF   = 10'd0;
  localparam logic [9:0] Y_MAX_DEF   = 10'd479;
  localparam logic [9:0] STEP_DEF    = 10'd1;
  localparam logic [9:0] TANK_W_DEF  = 10'd16;
  localparam logic [9:0] TANK_H_DEF  = 10'd16;
  localparam int         TIMEOUT_DEF = 16;

  function automatic logic key_valid(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
  endfunction

  function automatic dir_t key_dir(input logic [7:0] k);
    case (k)
      KEY_A:   return DIR_LEFT;
      KEY_S:   return DIR_DOWN;
      KEY_D:   return DIR_RIGHT;
      default: return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Brings the async VSYNC strobe into the Clk domain; one-cycle pulse on its rising edge,
// two cycles after the input is first sampled high. No backpressure.
module frame_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized value
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n) sh <= 3'b000;
    else        sh <= {sh[1:0], async_in};
  end

  assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/tank_motion_ctrl.sv
// Per-frame tank mover: keycode -> bounds check -> req/ack collision check -> commit.
// chk_req rises the cycle after fr_pulse; frames arriving while busy are dropped. Bounce retry: TANK_BOUNCE_EN.
module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter logic [9:0] X_START = X_START_DEF,
  parameter logic [9:0] Y_START = Y_START_DEF,
  parameter logic [9:0] X_MIN   = X_MIN_DEF,
  parameter logic [9:0] X_MAX   = X_MAX_DEF,
  parameter logic [9:0] Y_MIN   = Y_MIN_DEF,
  parameter logic [9:0] Y_MAX   = Y_MAX_DEF,
  parameter logic [9:0] STEP    = STEP_DEF,
  parameter logic [9:0] TANK_W  = TANK_W_DEF,
  parameter logic [9:0] TANK_H  = TANK_H_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       chk_req,
  output logic [9:0] X_Prop,
  output logic [9:0] Y_Prop,
  input  logic       chk_ack,
  input  logic       chk_hit,
  output logic [9:0] Tank_X,
  output logic [9:0] Tank_Y,
  output dir_t       Tank_Dir,
  output logic       moving
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  pos_t           pos_q, pos_d, prop_q, prop_d;
  dir_t           dir_q, dir_d;
  logic           req_q, req_d, mov_q, mov_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           fr_pulse, ack_seen, tmo_exp;

  frame_edge_sync u_sync (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .pulse    (fr_pulse)
  );

  // Widened to 12 bits so edge sums never wrap.
  function automatic logic is_blocked(input pos_t p, input dir_t d);
    logic [11:0] px, py;
    px = {2'b00, p.x};
    py = {2'b00, p.y};
    case (d)
      DIR_LEFT:  return px < ({2'b00, X_MIN} + {2'b00, STEP});
      DIR_RIGHT: return (px + {2'b00, TANK_W} + {2'b00, STEP}) > {2'b00, X_MAX};
      DIR_UP:    return py < ({2'b00, Y_MIN} + {2'b00, STEP});
      DIR_DOWN:  return (py + {2'b00, TANK_H} + {2'b00, STEP}) > {2'b00, Y_MAX};
      default:   return 1'b1;
    endcase
  endfunction

  function automatic pos_t step_pos(input pos_t p, input dir_t d);
    pos_t r;
    r = p;
    case (d)
      DIR_LEFT:  r.x = p.x - STEP;
      DIR_RIGHT: r.x = p.x + STEP;
      DIR_UP:    r.y = p.y - STEP;
      DIR_DOWN:  r.y = p.y + STEP;
      default:   r = p;
    endcase
    return r;
  endfunction

`ifdef TANK_BOUNCE_EN
  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return DIR_LEFT;
    endcase
  endfunction
`endif

  assign ack_seen = req_q & chk_ack;
  assign tmo_exp  = req_q & ~chk_ack & (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    prop_d  = prop_q;
    dir_d   = dir_q;
    req_d   = req_q;
    mov_d   = 1'b0;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (fr_pulse && key_valid(keycode)) begin
          dir_d = key_dir(keycode);
          if (!is_blocked(pos_q, key_dir(keycode))) begin
            prop_d  = step_pos(pos_q, key_dir(keycode));
            req_d   = 1'b1;
            tmo_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (ack_seen || tmo_exp) begin
          req_d   = 1'b0;
          tmo_d   = '0;
          state_d = IDLE;
          if (ack_seen && !chk_hit) begin
            pos_d = prop_q;
            mov_d = 1'b1;
          end
`ifdef TANK_BOUNCE_EN
          // Timeout counts as a hit, so it also earns a bounce attempt.
          else if (!is_blocked(pos_q, opposite(dir_q))) begin
            prop_d  = step_pos(pos_q, opposite(dir_q));
            state_d = BREQ;
          end
`endif
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef TANK_BOUNCE_EN
      BREQ: begin
        // Request launches one cycle after the REQ handshake closes.
        if (!req_q) begin
          req_d = 1'b1;
          tmo_d = '0;
        end else if (ack_seen || tmo_exp) begin
          req_d   = 1'b0;
          tmo_d   = '0;
          state_d = IDLE;
          if (ack_seen && !chk_hit) begin
            pos_d = prop_q;
            mov_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pos_q   <= '{x: X_START, y: Y_START};
      prop_q  <= '{x: X_START, y: Y_START};
      dir_q   <= DIR_UP;
      req_q   <= 1'b0;
      mov_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      prop_q  <= prop_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      mov_q   <= mov_d;
      tmo_q   <= tmo_d;
    end
  end

  assign chk_req  = req_q;
  assign X_Prop   = prop_q.x;
  assign Y_Prop   = prop_q.y;
  assign Tank_X   = pos_q.x;
  assign Tank_Y   = pos_q.y;
  assign Tank_Dir = dir_q;
  assign moving   = mov_q;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Scoreboard bench for tank_motion_ctrl: expected proposals/commits queued at stimulus, checked at output.
module tb_tank_motion_ctrl;
  import tank_pkg::*;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       chk_ack = 1'b0;
  logic       chk_hit = 1'b0;
  logic       chk_req, moving;
  logic [9:0] X_Prop, Y_Prop, Tank_X, Tank_Y;
  dir_t       Tank_Dir;

  logic       frame_clk0 = 1'b0;
  logic [7:0] keycode0 = 8'h00;
  logic       chk_ack0 = 1'b0;
  logic       chk_hit0 = 1'b0;
  logic       chk_req0, moving0;
  logic [9:0] X_Prop0, Y_Prop0, Tank_X0, Tank_Y0;
  dir_t       Tank_Dir0;

  int checks = 0;
  int errors = 0;
  exp_t prop_q[$];
  exp_t commit_q[$];

  always #5 Clk = ~Clk;

  tank_motion_ctrl u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .chk_req(chk_req), .X_Prop(X_Prop), .Y_Prop(Y_Prop),
    .chk_ack(chk_ack), .chk_hit(chk_hit),
    .Tank_X(Tank_X), .Tank_Y(Tank_Y), .Tank_Dir(Tank_Dir), .moving(moving)
  );

  tank_motion_ctrl #(.X_START(10'd0)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk0), .keycode(keycode0),
    .chk_req(chk_req0), .X_Prop(X_Prop0), .Y_Prop(Y_Prop0),
    .chk_ack(chk_ack0), .chk_hit(chk_hit0),
    .Tank_X(Tank_X0), .Tank_Y(Tank_Y0), .Tank_Dir(Tank_Dir0), .moving(moving0)
  );

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic pulse_frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (chk_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_exp(input bit to_commit, input logic [9:0] x, input logic [9:0] y);
    exp_t e;
    e.x = x;
    e.y = y;
    if (to_commit) commit_q.push_back(e);
    else           prop_q.push_back(e);
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (Tank_X !== 10'd320 || Tank_Y !== 10'd240) begin
      errors++; $display("FAIL reset_pos got %0d,%0d want 320,240", Tank_X, Tank_Y);
    end
    checks++;
    if (Tank_Dir !== DIR_UP || chk_req !== 1'b0 || moving !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got dir=%0d req=%b mov=%b want 0,0,0", Tank_Dir, chk_req, moving);
    end
    checks++;
    if (X_Prop !== 10'd320 || Y_Prop !== 10'd240) begin
      errors++; $display("FAIL reset_prop got %0d,%0d want 320,240", X_Prop, Y_Prop);
    end
    checks++;
    if (Tank_X0 !== 10'd0) begin
      errors++; $display("FAIL reset_pos0 got %0d want 0", Tank_X0);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_move_right();
    bit got;
    exp_t e;
    keycode = KEY_D;
    push_exp(1'b0, 10'd321, 10'd240);
    pulse_frame();
    wait_req(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL right_req got no chk_req want chk_req=1");
    end else begin
      e = prop_q.pop_front();
      checks++;
      if (X_Prop !== e.x || Y_Prop !== e.y) begin
        errors++; $display("FAIL right_prop got %0d,%0d want %0d,%0d", X_Prop, Y_Prop, e.x, e.y);
      end
      repeat (3) @(negedge Clk);
      checks++;
      if (chk_req !== 1'b1 || X_Prop !== e.x) begin
        errors++; $display("FAIL right_hold got req=%b x=%0d want 1,%0d", chk_req, X_Prop, e.x);
      end
      chk_ack = 1'b1;
      chk_hit = 1'b0;
      push_exp(1'b1, 10'd321, 10'd240);
      @(negedge Clk);
      chk_ack = 1'b0;
      e = commit_q.pop_front();
      checks++;
      if (moving !== 1'b1 || chk_req !== 1'b0) begin
        errors++; $display("FAIL right_done got mov=%b req=%b want 1,0", moving, chk_req);
      end
      checks++;
      if (Tank_X !== e.x || Tank_Y !== e.y || Tank_Dir !== DIR_RIGHT) begin
        errors++; $display("FAIL right_commit got %0d,%0d,d%0d want %0d,%0d,d1", Tank_X, Tank_Y, Tank_Dir, e.x, e.y);
      end
      @(negedge Clk);
      checks++;
      if (moving !== 1'b0) begin
        errors++; $display("FAIL right_pulse got mov=%b want 0", moving);
      end
    end
  endtask

  task automatic test_left_hit();
    bit got;
    bit bad;
    exp_t e;
    do_reset();
    keycode = KEY_A;
    push_exp(1'b0, 10'd319, 10'd240);
    pulse_frame();
    wait_req(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL left_req got no chk_req want chk_req=1");
    end else begin
      e = prop_q.pop_front();
      checks++;
      if (X_Prop !== e.x || Y_Prop !== e.y) begin
        errors++; $display("FAIL left_prop got %0d,%0d want %0d,%0d", X_Prop, Y_Prop, e.x, e.y);
      end
      // Ack in the same cycle the request first rose.
      chk_ack = 1'b1;
      chk_hit = 1'b1;
`ifdef TANK_BOUNCE_EN
      push_exp(1'b0, 10'd321, 10'd240);
`endif
      @(negedge Clk);
      chk_ack = 1'b0;
      chk_hit = 1'b0;
      checks++;
      if (chk_req !== 1'b0 || moving !== 1'b0 || Tank_X !== 10'd320 || Tank_Dir !== DIR_LEFT) begin
        errors++; $display("FAIL left_hit got req=%b mov=%b x=%0d d%0d want 0,0,320,d3", chk_req, moving, Tank_X, Tank_Dir);
      end
`ifdef TANK_BOUNCE_EN
      wait_req(got);
      checks++;
      if (!got) begin
        errors++; $display("FAIL bounce_req got no chk_req want chk_req=1");
      end else begin
        e = prop_q.pop_front();
        checks++;
        if (X_Prop !== e.x || Y_Prop !== e.y) begin
          errors++; $display("FAIL bounce_prop got %0d,%0d want %0d,%0d", X_Prop, Y_Prop, e.x, e.y);
        end
        chk_ack = 1'b1;
        push_exp(1'b1, 10'd321, 10'd240);
        @(negedge Clk);
        chk_ack = 1'b0;
        e = commit_q.pop_front();
        checks++;
        if (moving !== 1'b1 || Tank_X !== e.x || Tank_Dir !== DIR_LEFT) begin
          errors++; $display("FAIL bounce_commit got mov=%b x=%0d d%0d want 1,%0d,d3", moving, Tank_X, Tank_Dir, e.x);
        end
      end
`else
      bad = 1'b0;
      repeat (6) begin
        @(negedge Clk);
        if (moving !== 1'b0 || chk_req !== 1'b0 || Tank_X !== 10'd320) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++; $display("FAIL left_held got activity after hit x=%0d want idle at 320", Tank_X);
      end
`endif
    end
  endtask

  task automatic test_bound_left();
    bit saw_req;
    keycode0 = KEY_A;
    @(negedge Clk);
    frame_clk0 = 1'b1;
    saw_req = 1'b0;
    repeat (2) @(negedge Clk);
    frame_clk0 = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (chk_req0 !== 1'b0) saw_req = 1'b1;
    end
    checks++;
    if (saw_req) begin
      errors++; $display("FAIL bound_noreq got chk_req=1 want 0");
    end
    checks++;
    if (Tank_X0 !== 10'd0 || Tank_Dir0 !== DIR_LEFT || moving0 !== 1'b0) begin
      errors++; $display("FAIL bound_pos got x=%0d d%0d mov=%b want 0,d3,0", Tank_X0, Tank_Dir0, moving0);
    end
  endtask

  task automatic test_timeout();
    bit got;
    bit early;
    bit mov_seen;
    exp_t e;
    do_reset();
    keycode = KEY_S;
    push_exp(1'b0, 10'd320, 10'd241);
    pulse_frame();
    wait_req(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL tmo_req got no chk_req want chk_req=1");
    end else begin
      e = prop_q.pop_front();
      checks++;
      if (X_Prop !== e.x || Y_Prop !== e.y) begin
        errors++; $display("FAIL tmo_prop got %0d,%0d want %0d,%0d", X_Prop, Y_Prop, e.x, e.y);
      end
      early = 1'b0;
      mov_seen = 1'b0;
      for (int i = 1; i <= 15; i++) begin
        @(negedge Clk);
        if (chk_req !== 1'b1) early = 1'b1;
        if (moving !== 1'b0) mov_seen = 1'b1;
      end
      checks++;
      if (early) begin
        errors++; $display("FAIL tmo_early got chk_req=0 before 16 cycles want 1");
      end
      @(negedge Clk);
      checks++;
      if (chk_req !== 1'b0) begin
        errors++; $display("FAIL tmo_drop got chk_req=%b want 0", chk_req);
      end
      repeat (3) begin
        @(negedge Clk);
        if (moving !== 1'b0) mov_seen = 1'b1;
      end
      checks++;
      if (mov_seen || Tank_Y !== 10'd240 || Tank_Dir !== DIR_DOWN) begin
        errors++; $display("FAIL tmo_hold got y=%0d mov=%b d%0d want 240,0,d2", Tank_Y, mov_seen, Tank_Dir);
      end
    end
  endtask

  task automatic test_frame_during_req();
    bit got;
    bit extra;
    exp_t e;
    do_reset();
    keycode = KEY_D;
    push_exp(1'b0, 10'd321, 10'd240);
    pulse_frame();
    wait_req(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL drop_req got no chk_req want chk_req=1");
    end else begin
      e = prop_q.pop_front();
      pulse_frame();
      repeat (4) @(negedge Clk);
      checks++;
      if (X_Prop !== e.x || chk_req !== 1'b1) begin
        errors++; $display("FAIL drop_prop got x=%0d req=%b want %0d,1", X_Prop, chk_req, e.x);
      end
      chk_ack = 1'b1;
      push_exp(1'b1, 10'd321, 10'd240);
      @(negedge Clk);
      chk_ack = 1'b0;
      e = commit_q.pop_front();
      checks++;
      if (moving !== 1'b1 || Tank_X !== e.x) begin
        errors++; $display("FAIL drop_commit got mov=%b x=%0d want 1,%0d", moving, Tank_X, e.x);
      end
      extra = 1'b0;
      repeat (10) begin
        @(negedge Clk);
        if (chk_req !== 1'b0) extra = 1'b1;
      end
      checks++;
      if (extra) begin
        errors++; $display("FAIL drop_single got a second chk_req want none");
      end
    end
  endtask

  task automatic test_reset_mid_req();
    bit got;
    keycode = KEY_D;
    pulse_frame();
    wait_req(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL rstreq_req got no chk_req want chk_req=1");
    end else begin
      Reset_n = 1'b0;
      @(negedge Clk);
      checks++;
      if (chk_req !== 1'b0 || Tank_X !== 10'd320 || Tank_Y !== 10'd240 || X_Prop !== 10'd320) begin
        errors++; $display("FAIL rstreq_state got req=%b pos=%0d,%0d px=%0d want 0,320,240,320", chk_req, Tank_X, Tank_Y, X_Prop);
      end
      Reset_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_left_hit();
    test_bound_left();
    test_timeout();
    test_frame_during_req();
    test_reset_mid_req();
    checks++;
    if (prop_q.size() != 0 || commit_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d,%0d left want 0,0", prop_q.size(), commit_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
